// File: rtl/fetch_queue_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// The fetch stage uses the master view; the imem/decode side uses the slave view.
interface fetch_queue_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-3:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [INSN_WIDTH-1:0] imem_rsp_insn;
    logic                  stage_out_insn_valid;
    logic                  stage_out_insn_ready;
    logic [ADDR_WIDTH-3:0] stage_out_insn_addr;
    logic [INSN_WIDTH-1:0] stage_out_insn;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_insn,
        output stage_out_insn_valid, stage_out_insn_addr, stage_out_insn,
        input  stage_out_insn_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_insn,
        input  stage_out_insn_valid, stage_out_insn_addr, stage_out_insn,
        output stage_out_insn_ready
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch stage: credit-limited imem requests, in-order responses, decoupling queue to decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue_stage #(
    parameter int ADDR_WIDTH      = 32,
    parameter int INSN_WIDTH      = 32,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-3:0] rst_addr,
    input  logic                  backend_redirect_en,
    input  logic [ADDR_WIDTH-3:0] backend_redirect_addr,
    fetch_queue_stage_if.master   bus
);
    localparam int AW  = ADDR_WIDTH - 2;
    localparam int QPW = $clog2(QUEUE_DEPTH);
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW  = $clog2(QUEUE_DEPTH + MAX_OUTSTANDING + 1);

    logic [AW-1:0]         pc_reg, pc_next;
    logic [QPW-1:0]        rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next, rd_ptr_step;
    logic [CW-1:0]         count_reg, count_next;
    logic [OW-1:0]         outstanding_reg, outstanding_next;
    logic [OW-1:0]         drop_cnt_reg, drop_cnt_next;
    logic [FPW-1:0]        af_rd_ptr_reg, af_rd_ptr_next, af_wr_ptr_reg, af_wr_ptr_next;
    logic [INSN_WIDTH-1:0] head_insn_reg, head_insn_next;
    logic [AW-1:0]         head_addr_reg, head_addr_next;

    logic [INSN_WIDTH-1:0] q_insn_mem [QUEUE_DEPTH];
    logic [AW-1:0]         q_addr_mem [QUEUE_DEPTH];
    logic [AW-1:0]         af_mem     [MAX_OUTSTANDING];

    logic          credit_ok, req_valid, req_fire, rsp_fire, rsp_discard;
    logic          queue_valid, enq, deq;
    logic [SW-1:0] credit_sum;
    logic [AW-1:0] rsp_addr;

    function automatic logic [FPW-1:0] af_inc(input logic [FPW-1:0] p);
        return (p == FPW'(MAX_OUTSTANDING - 1)) ? '0 : p + FPW'(1);
    endfunction

    // Stale in-flight requests keep their credit until they return.
    assign credit_sum  = SW'(outstanding_reg) + SW'(count_reg);
    assign credit_ok   = (outstanding_reg < OW'(MAX_OUTSTANDING)) &&
                         (credit_sum < SW'(QUEUE_DEPTH));
    assign req_valid   = !rst && !backend_redirect_en && credit_ok;
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign rsp_fire    = bus.imem_rsp_valid;
    assign rsp_addr    = af_mem[af_rd_ptr_reg];
    assign rsp_discard = (drop_cnt_reg != '0) || backend_redirect_en;
    assign queue_valid = (count_reg != '0) && !backend_redirect_en;
    assign deq         = queue_valid && bus.stage_out_insn_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_reg;

`ifdef FETCH_BYPASS_EN
    logic bypass_avail, bypass_take;

    // A taken bypass skips the queue entirely, so the queue must be empty.
    assign bypass_avail = !rst && (count_reg == '0) && rsp_fire && !rsp_discard;
    assign bypass_take  = bypass_avail && bus.stage_out_insn_ready;
    assign enq          = rsp_fire && !rsp_discard && !bypass_take;

    assign bus.stage_out_insn_valid = queue_valid || bypass_avail;
    assign bus.stage_out_insn       = bypass_avail ? bus.imem_rsp_insn : head_insn_reg;
    assign bus.stage_out_insn_addr  = bypass_avail ? rsp_addr : head_addr_reg;
`else
    assign enq = rsp_fire && !rsp_discard;

    assign bus.stage_out_insn_valid = queue_valid;
    assign bus.stage_out_insn       = head_insn_reg;
    assign bus.stage_out_insn_addr  = head_addr_reg;
`endif

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = outstanding_reg + OW'(req_fire) - OW'(rsp_fire);
        drop_cnt_next    = drop_cnt_reg;
        af_wr_ptr_next   = req_fire ? af_inc(af_wr_ptr_reg) : af_wr_ptr_reg;
        af_rd_ptr_next   = rsp_fire ? af_inc(af_rd_ptr_reg) : af_rd_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        count_next       = count_reg;

        if (backend_redirect_en) begin
            pc_next       = backend_redirect_addr;
            // Everything still in flight after this cycle is stale.
            drop_cnt_next = outstanding_reg - OW'(rsp_fire);
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (req_fire) begin
                pc_next = pc_reg + AW'(1);
            end
            if (rsp_fire && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - OW'(1);
            end
            rd_ptr_next = rd_ptr_reg + QPW'(deq);
            wr_ptr_next = wr_ptr_reg + QPW'(enq);
            count_next  = count_reg + CW'(enq) - CW'(deq);
        end
    end

    // Registered head read; forward the incoming word when it lands in the next head slot.
    always_comb begin
        rd_ptr_step = rd_ptr_reg + QPW'(deq);
        if (enq && (wr_ptr_reg == rd_ptr_step)) begin
            head_insn_next = bus.imem_rsp_insn;
            head_addr_next = rsp_addr;
        end else begin
            head_insn_next = q_insn_mem[rd_ptr_step];
            head_addr_next = q_addr_mem[rd_ptr_step];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= rst_addr;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            af_rd_ptr_reg   <= '0;
            af_wr_ptr_reg   <= '0;
            head_insn_reg   <= '0;
            head_addr_reg   <= '0;
        end else begin
            pc_reg          <= pc_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            af_rd_ptr_reg   <= af_rd_ptr_next;
            af_wr_ptr_reg   <= af_wr_ptr_next;
            head_insn_reg   <= head_insn_next;
            head_addr_reg   <= head_addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_insn_mem[wr_ptr_reg] <= bus.imem_rsp_insn;
            q_addr_mem[wr_ptr_reg] <= rsp_addr;
        end
        if (req_fire) begin
            af_mem[af_wr_ptr_reg] <= pc_reg;
        end
    end

    queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        enq |-> (count_reg < CW'(QUEUE_DEPTH)));

    rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        rsp_fire |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: imem model with configurable latency and a
// sequential reference for request and decode address streams.
module tb_fetch_queue_stage;
    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rst_addr;
    logic          backend_redirect_en;
    logic [AW-1:0] backend_redirect_addr;

    always #5 clk = ~clk;

    fetch_queue_stage_if #(.ADDR_WIDTH(32), .INSN_WIDTH(32)) bus ();

    fetch_queue_stage #(
        .ADDR_WIDTH(32), .INSN_WIDTH(32), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rst_addr             (rst_addr),
        .backend_redirect_en  (backend_redirect_en),
        .backend_redirect_addr(backend_redirect_addr),
        .bus                  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit            dec_ready_k, dec_ready_rand, req_ready_rand, redir_k;
    logic [AW-1:0] redir_addr_k;
    int            lat_min, lat_max;

    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    logic [AW-1:0] exp_req_pc, exp_dec_pc;
    logic [AW-1:0] req_addr_log[$], dec_addr_log[$];
    int            req_cyc_log[$], dec_cyc_log[$];
    bit            last_req_valid, last_out_valid;

    function automatic logic [31:0] insn_of(input logic [AW-1:0] a);
        return {2'b10, a} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step();
        bit rd;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_insn  = '0;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_insn  = insn_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        bus.imem_req_ready = req_ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        rd = dec_ready_rand ? ($urandom_range(0, 3) != 0) : dec_ready_k;
        bus.stage_out_insn_ready = rd;
        backend_redirect_en   = redir_k;
        backend_redirect_addr = redir_addr_k;
        #1;
        last_req_valid = bus.imem_req_valid;
        last_out_valid = bus.stage_out_insn_valid;
        if (redir_k) begin
            check("redir_req_valid", bus.imem_req_valid, 0);
            check("redir_out_valid", bus.stage_out_insn_valid, 0);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_req_pc);
            req_addr_log.push_back(bus.imem_req_addr);
            req_cyc_log.push_back(cyc);
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            exp_req_pc = exp_req_pc + AW'(1);
        end
        if (bus.stage_out_insn_valid && rd) begin
            $display("dec cyc=%0d addr=%h insn=%h", cyc, bus.stage_out_insn_addr, bus.stage_out_insn);
            check("dec_addr", bus.stage_out_insn_addr, exp_dec_pc);
            check("dec_insn", bus.stage_out_insn, insn_of(exp_dec_pc));
            dec_addr_log.push_back(bus.stage_out_insn_addr);
            dec_cyc_log.push_back(cyc);
            exp_dec_pc = exp_dec_pc + AW'(1);
        end
        if (redir_k) begin
            exp_req_pc = redir_addr_k;
            exp_dec_pc = redir_addr_k;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic [AW-1:0] addr, input int lmin, input int lmax);
        rst_addr = addr;
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_insn = '0;
        bus.stage_out_insn_ready = 1'b0;
        backend_redirect_en = 1'b0;
        backend_redirect_addr = '0;
        redir_k = 1'b0;
        redir_addr_k = '0;
        dec_ready_rand = 1'b0;
        req_ready_rand = 1'b0;
        lat_min = lmin;
        lat_max = lmax;
        pend_addr.delete();
        pend_due.delete();
        req_addr_log.delete();
        req_cyc_log.delete();
        dec_addr_log.delete();
        dec_cyc_log.delete();
        @(negedge clk);
        @(negedge clk);
        bus.imem_req_ready = 1'b1;
        bus.stage_out_insn_ready = 1'b1;
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_out_valid", bus.stage_out_insn_valid, 0);
        check("rst_out_addr", bus.stage_out_insn_addr, 0);
        check("rst_out_insn", bus.stage_out_insn, 0);
        check("rst_req_addr", bus.imem_req_addr, addr);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        exp_req_pc = addr;
        exp_dec_pc = addr;
    endtask

    initial begin
        rst = 1'b1;
        rst_addr = '0;

        // Streaming from reset, latency 1, decode always ready.
        do_reset(30'h100, 1, 1);
        dec_ready_k = 1'b1;
        steps(10);
        check("t1_first_req_addr", req_addr_log[0], 30'h100);
        check("t1_first_req_cyc", req_cyc_log[0], 0);
        check("t1_n_req", req_addr_log.size(), 10);
        check("t1_n_dec", dec_addr_log.size(), 8);
        check("t1_first_dec_cyc", dec_cyc_log[0], 2);

        // Decode stalled: credit stops fetch after exactly four requests.
        do_reset(30'h100, 1, 1);
        dec_ready_k = 1'b0;
        steps(10);
        check("t2_n_req_stall", req_addr_log.size(), 4);
        check("t2_req_valid_stall", last_req_valid, 0);
        check("t2_n_dec_stall", dec_addr_log.size(), 0);
        dec_ready_k = 1'b1;
        steps(10);
        check("t2_resume_addr", req_addr_log[4], 30'h104);
        check("t2_resume_cyc", req_cyc_log[4], 11);
        check("t2_n_dec", dec_addr_log.size(), 10);
        check("t2_first_dec_cyc", dec_cyc_log[0], 10);

        // Redirect with two requests in flight, latency 3.
        do_reset(30'h100, 3, 3);
        dec_ready_k = 1'b1;
        steps(2);
        redir_k = 1'b1;
        redir_addr_k = 30'h200;
        step();
        redir_k = 1'b0;
        steps(10);
        check("t3_req_after_redir", req_addr_log[2], 30'h200);
        check("t3_req_after_redir_cyc", req_cyc_log[2], 4);
        check("t3_first_dec", dec_addr_log[0], 30'h200);
        check("t3_first_dec_cyc", dec_cyc_log[0], 8);

        // Redirect coincident with a response and a decode handshake.
        do_reset(30'h100, 1, 1);
        dec_ready_k = 1'b1;
        steps(4);
        check("t4_n_dec_before", dec_addr_log.size(), 2);
        redir_k = 1'b1;
        redir_addr_k = 30'h300;
        step();
        redir_k = 1'b0;
        step();
        check("t4_flushed", last_out_valid, 0);
        steps(5);
        check("t4_first_dec", dec_addr_log[2], 30'h300);
        check("t4_first_dec_cyc", dec_cyc_log[2], 7);

        // Word-address wrap.
        do_reset(30'h3FFF_FFFF, 1, 1);
        dec_ready_k = 1'b1;
        steps(4);
        check("t5_req0", req_addr_log[0], 30'h3FFF_FFFF);
        check("t5_req1", req_addr_log[1], 30'h0);
        check("t5_dec1", dec_addr_log[1], 30'h0);

        // Random request ready, decode ready and latency, with occasional redirects.
        do_reset(30'h4000, 1, 3);
        req_ready_rand = 1'b1;
        dec_ready_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            redir_k = ((i % 97) == 50);
            redir_addr_k = AW'(32'h8000 + i * 16);
            step();
        end
        redir_k = 1'b0;
        check("t6_progress", dec_addr_log.size() > 50, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
